// File: rtl/vram_pkg.sv
// Shared constants and enums for the frame-buffer scheduler.
// Module parameters default to these values.
package vram_pkg;

    localparam int VRAM_DATA_W  = 8;
    localparam int VRAM_ADDR_W  = 15;
    localparam int VRAM_FB_W    = 160;
    localparam int VRAM_FB_H    = 120;
    localparam int VRAM_FB_SIZE = VRAM_FB_W * VRAM_FB_H;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Which requester owns the RAM port in the current cycle.
    typedef enum logic [1:0] {
        SEL_DISP = 2'd0,
        SEL_CLR  = 2'd1,
        SEL_FIFO = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

endpackage

// File: rtl/vram_scheduler_if.sv
// Bundle of VGA timing, pixel-write, clear, RAM and display-output signals.
// The slave modport is the scheduler's view of the bundle.
interface vram_scheduler_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);
    logic [9:0]        x;
    logic [9:0]        y;
    logic              hsync_in;
    logic              vsync_in;
    logic              blank_b_in;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] pixel;
    logic              hsync;
    logic              vsync;
    logic              blank_b;

    modport slave (
        input  x, y, hsync_in, vsync_in, blank_b_in,
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  clr_start, clr_color,
        output clr_busy,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output pixel, hsync, vsync, blank_b
    );

    modport master (
        output x, y, hsync_in, vsync_in, blank_b_in,
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output clr_start, clr_color,
        input  clr_busy,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  pixel, hsync, vsync, blank_b
    );

endinterface

// File: rtl/vram_wfifo.sv
// Small synchronous FIFO with show-ahead head and full/empty flags.
// A push is taken while full only if the same cycle pops.
module vram_wfifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Extra pointer MSB separates the full and empty cases.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + PTR_ONE;
        if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vram_scheduler.sv
// Arbitrates one frame-buffer RAM port between display fetch, screen clear and
// a write FIFO, and re-times sync/blank to match the fetched pixel.
module vram_scheduler
    import vram_pkg::*;
#(
    parameter int HACTIVE     = 640,
    parameter int VACTIVE     = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = VRAM_FB_W,
    parameter int FB_H        = VRAM_FB_H,
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic             vgaclk,
    input  logic             reset,
    vram_scheduler_if.slave  bus
);
    localparam int                FB_SIZE   = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W+1)'(FB_SIZE);
    localparam logic [2:0]        SYNC_RST  = 3'b110;   // {hsync, vsync, blank_b}

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;
    sel_e              sel;

    logic              disp_slot;
    logic [ADDR_W-1:0] x_fb, y_fb, disp_addr;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              head_in_range;

    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic              ram_we_c;
    logic              clr_busy_c;

    logic [2:0]        sync_q [2];
    logic              slot_q;
    logic [DATA_W-1:0] pixel_q;

    // ---------------- display address ----------------
    assign disp_slot = bus.blank_b_in && (bus.x[SCALE_SHIFT-1:0] == '0)
                       && (int'(bus.x) < HACTIVE) && (int'(bus.y) < VACTIVE);
    assign x_fb = ADDR_W'(bus.x >> SCALE_SHIFT);
    assign y_fb = ADDR_W'(bus.y >> SCALE_SHIFT);

    generate
        if (FB_W == 160) begin : g_addr_shift
            assign disp_addr = (y_fb << 7) + (y_fb << 5) + x_fb;
        end else begin : g_addr_mul
            assign disp_addr = (y_fb * ADDR_W'(FB_W)) + x_fb;
        end
    endgenerate

    // ---------------- write FIFO ----------------
    assign bus.wr_ready = ~fifo_full;
    assign fifo_push    = bus.wr_valid & ~fifo_full;
    assign head_addr    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign head_data    = fifo_head[DATA_W-1:0];
    assign head_in_range = ({1'b0, head_addr} < FB_LIMIT);

    vram_wfifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (vgaclk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .wdata_i ({bus.wr_addr, bus.wr_data}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- arbitration ----------------
    always_comb begin
        sel = SEL_NONE;
        if (!reset)                sel = SEL_NONE;
        else if (disp_slot)        sel = SEL_DISP;
        else if (state_q == CLEAR) sel = SEL_CLR;
        else if (!fifo_empty)      sel = SEL_FIFO;
    end

    // ---------------- clear FSM: state register ----------------
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            clr_ptr_q   <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
        end
    end

    // ---------------- clear FSM: next state ----------------
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_color_d = clr_color_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d     = CLEAR;
                    clr_ptr_d   = '0;
                    clr_color_d = bus.clr_color;
                end
            end
            CLEAR: begin
                if (sel == SEL_CLR) begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                    if (clr_ptr_q == LAST_ADDR) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Address and write data hold their last driven value on idle cycles.
    always_comb begin
        ram_addr_c  = ram_addr_q;
        ram_wdata_c = ram_wdata_q;
        ram_we_c    = 1'b0;
        fifo_pop    = 1'b0;
        clr_busy_c  = (state_q == CLEAR);
        case (sel)
            SEL_DISP: ram_addr_c = disp_addr;
            SEL_CLR: begin
                ram_addr_c  = clr_ptr_q;
                ram_wdata_c = clr_color_q;
                ram_we_c    = 1'b1;
            end
            SEL_FIFO: begin
                fifo_pop = 1'b1;
                if (head_in_range) begin
                    ram_addr_c  = head_addr;
                    ram_wdata_c = head_data;
                    ram_we_c    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ram_addr  = ram_addr_c;
    assign bus.ram_wdata = ram_wdata_c;
    assign bus.ram_we    = ram_we_c;
    assign bus.clr_busy  = clr_busy_c;

    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr_c;
            ram_wdata_q <= ram_wdata_c;
        end
    end

    // ---------------- pixel and sync pipeline ----------------
    // RAM data is valid the cycle after the slot; capture it then so the
    // pixel lines up with the two-stage delayed sync/blank.
    always_ff @(posedge vgaclk or negedge reset) begin
        if (!reset) begin
            sync_q[0] <= SYNC_RST;
            sync_q[1] <= SYNC_RST;
            slot_q    <= 1'b0;
            pixel_q   <= '0;
        end else begin
            sync_q[0] <= {bus.hsync_in, bus.vsync_in, bus.blank_b_in};
            sync_q[1] <= sync_q[0];
            slot_q    <= disp_slot;
            if (slot_q) pixel_q <= bus.ram_rdata;
        end
    end

    assign bus.hsync   = sync_q[1][2];
    assign bus.vsync   = sync_q[1][1];
    assign bus.blank_b = sync_q[1][0];
    assign bus.pixel   = sync_q[1][0] ? pixel_q : '0;

endmodule

// File: tb/tb_vram_scheduler.sv
// Self-checking bench for vram_scheduler: directed vectors, multi-cycle
// sequences and randomized traffic checked against a frame-buffer model.
module tb_vram_scheduler;
    import vram_pkg::*;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 8;
    localparam int FB_SIZE = 19200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vram_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .vgaclk (clk),
        .reset  (rst_n),
        .bus    (bus.slave)
    );

    // ---------------- RAM model and write monitor ----------------
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t               wlog [$];
    logic [DATA_W-1:0] mem [0:32767];
    logic [DATA_W-1:0] exp_mem [0:FB_SIZE-1];
    int                cyc       = 0;
    int                slot_viol = 0;
    logic              bd_we     = 1'b0;
    logic [ADDR_W-1:0] bd_addr   = '0;
    logic [DATA_W-1:0] bd_data   = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wlog.push_back('{bus.ram_addr, bus.ram_wdata, cyc});
            if (bus.blank_b_in && bus.x[1:0] == 2'b00 && bus.x < 10'd640)
                slot_viol <= slot_viol + 1;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
        cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [ADDR_W-1:0] addr;
    } disp_vec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       bl;
        logic       hs;
        logic       vs;
    } hist_t;

    initial begin
        disp_vec_t dv [6];
        hist_t     hq [$];
        hist_t     p;
        int        ls, n0, idx, first_idle, snap_idx, bad, n_inrange;
        logic      snap_ready, acc;
        logic [9:0] yy;
        logic [DATA_W-1:0] exp_pix;

        dv[0] = '{10'd0,   10'd0,   15'd0};
        dv[1] = '{10'd4,   10'd4,   15'd161};
        dv[2] = '{10'd8,   10'd0,   15'd2};
        dv[3] = '{10'd0,   10'd4,   15'd160};
        dv[4] = '{10'd320, 10'd240, 15'd9680};
        dv[5] = '{10'd636, 10'd479, 15'd19199};

        bus.x = '0; bus.y = '0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.blank_b_in = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.clr_start = 1'b0; bus.clr_color = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_pixel",   bus.pixel, 0);
        check("rst_we",      bus.ram_we, 0);
        check("rst_addr",    bus.ram_addr, 0);
        check("rst_wdata",   bus.ram_wdata, 0);
        check("rst_busy",    bus.clr_busy, 0);
        check("rst_ready",   bus.wr_ready, 1);
        check("rst_hsync",   bus.hsync, 1);
        check("rst_vsync",   bus.vsync, 1);
        check("rst_blank",   bus.blank_b, 0);
        bus.blank_b_in = 1'b0; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        rst_n = 1'b1;
        tick();

        // ---- display address table ----
        foreach (dv[i]) begin
            bus.x = dv[i].x; bus.y = dv[i].y; bus.blank_b_in = 1'b1;
            #1;
            check("disp_addr", bus.ram_addr, dv[i].addr);
            check("disp_we",   bus.ram_we, 0);
            $display("disp vec %0d: x=%0d y=%0d addr=%0d", i, dv[i].x, dv[i].y, bus.ram_addr);
            tick();
        end
        bus.blank_b_in = 1'b0;
        tick();

        // ---- display fetch alignment ----
        bd_we = 1'b1; bd_addr = 15'd161; bd_data = 8'hA5;
        tick();
        bd_addr = 15'd162; bd_data = 8'h5A;
        tick();
        bd_we = 1'b0;
        bus.y = 10'd4; bus.blank_b_in = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.x = 10'(4 + k);
            #1;
            if (k == 0) check("fetch_addr", bus.ram_addr, 161);
            if (k >= 2 && k <= 5) begin
                check("fetch_pixel", bus.pixel, 8'hA5);
                check("fetch_blank", bus.blank_b, 1);
            end
            if (k == 6) check("fetch_next", bus.pixel, 8'h5A);
            tick();
        end
        $display("fetch: x=4..10 y=4 pixel sequence checked");

        // ---- write during active video waits past the slot ----
        bus.x = 10'd0; bus.y = 10'd0; bus.blank_b_in = 1'b1;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 8'h3C;
        #1;
        check("slotwr_ready", bus.wr_ready, 1);
        check("slotwr_no_we", bus.ram_we, 0);
        tick();
        bus.wr_valid = 1'b0; bus.x = 10'd1;
        #1;
        check("slotwr_we",    bus.ram_we, 1);
        check("slotwr_addr",  bus.ram_addr, 5);
        check("slotwr_data",  bus.ram_wdata, 8'h3C);
        $display("slot write: we=%0b addr=%0d data=0x%0h", bus.ram_we, bus.ram_addr, bus.ram_wdata);
        tick();
        bus.blank_b_in = 1'b0;
        tick();

        // ---- out-of-range write is consumed silently ----
        n0 = wlog.size();
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 8'h77;
        #1;
        check("oor_ready", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("oor_we", bus.ram_we, 0);
        repeat (6) tick();
        check("oor_nowrite", wlog.size() - n0, 0);
        $display("out-of-range write: writes seen=%0d", wlog.size() - n0);

        // ---- full clear with FIFO backpressure and ignored restart ----
        ls = wlog.size();
        bus.clr_start = 1'b1; bus.clr_color = 8'hFF;
        tick();
        bus.clr_start = 1'b0;
        check("clr_busy_rise", bus.clr_busy, 1);
        bus.clr_start = 1'b1; bus.clr_color = 8'h11;
        tick();
        bus.clr_start = 1'b0;
        idx = 0; first_idle = -1; snap_idx = -1; snap_ready = 1'b1;
        for (int c = 0; c < 21000; c++) begin
            bus.wr_valid = (idx < 5);
            bus.wr_addr  = 15'(10 + idx);
            bus.wr_data  = 8'(idx + 1);
            #1;
            acc = bus.wr_valid && bus.wr_ready;
            if (c == 10) begin snap_idx = idx; snap_ready = bus.wr_ready; end
            tick();
            if (acc) idx++;
            if (!bus.clr_busy && first_idle < 0) first_idle = cyc;
            if (first_idle >= 0 && idx == 5) break;
        end
        bus.wr_valid = 1'b0;
        check("fifo_full_accepts", snap_idx, 4);
        check("fifo_full_ready",   snap_ready, 0);
        check("fifo_all_accepted", idx, 5);
        repeat (8) tick();
        check("clr_total_writes", wlog.size() - ls, 19205);
        bad = 0;
        for (int i = 0; i < FB_SIZE; i++) begin
            if (ls + i >= wlog.size()) bad++;
            else if (wlog[ls+i].addr != 15'(i) || wlog[ls+i].data != 8'hFF) bad++;
        end
        check("clr_seq_bad", bad, 0);
        if (wlog.size() >= ls + 19205) begin
            check("clr_busy_fall", first_idle, wlog[ls+19199].cyc + 1);
            for (int k = 0; k < 5; k++) begin
                check("fifo_order_addr", wlog[ls+19200+k].addr, 10 + k);
                check("fifo_order_data", wlog[ls+19200+k].data, k + 1);
            end
        end else begin
            check("clr_log_short", wlog.size() - ls, 19205);
        end
        $display("clear: writes=%0d busy_fall_cyc=%0d", wlog.size() - ls, first_idle);

        for (int a = 0; a < FB_SIZE; a++) exp_mem[a] = 8'hFF;
        for (int k = 0; k < 5; k++) exp_mem[10+k] = 8'(k + 1);

        // ---- randomized writes against the frame-buffer model ----
        n0 = wlog.size(); n_inrange = 0;
        for (int c = 0; c < 600; c++) begin
            bus.blank_b_in = 1'($urandom_range(0, 1));
            bus.x = 10'($urandom_range(0, 639));
            bus.y = 10'($urandom_range(0, 479));
            bus.wr_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) == 0) bus.wr_addr = 15'($urandom_range(19200, 32767));
            else                           bus.wr_addr = 15'($urandom_range(0, 63));
            bus.wr_data = 8'($urandom);
            #1;
            if (bus.wr_valid && bus.wr_ready && bus.wr_addr < 15'd19200) begin
                exp_mem[bus.wr_addr] = bus.wr_data;
                n_inrange++;
            end
            tick();
        end
        bus.wr_valid = 1'b0; bus.blank_b_in = 1'b0;
        repeat (10) tick();
        bad = 0;
        for (int a = 0; a < FB_SIZE; a++) if (mem[a] !== exp_mem[a]) bad++;
        check("rand_mem_bad", bad, 0);
        check("rand_write_count", wlog.size() - n0, n_inrange);
        $display("random writes: in-range accepted=%0d ram writes=%0d", n_inrange, wlog.size() - n0);

        // ---- randomized display scan against the model ----
        for (int line = 0; line < 3; line++) begin
            yy = (line == 0) ? 10'($urandom_range(0, 3)) : 10'($urandom_range(0, 479));
            for (int xx = 0; xx < 800; xx++) begin
                bus.x = 10'(xx); bus.y = yy;
                bus.blank_b_in = (xx < 640);
                bus.hsync_in = 1'($urandom_range(0, 1));
                bus.vsync_in = 1'($urandom_range(0, 1));
                hq.push_back('{bus.x, bus.y, bus.blank_b_in, bus.hsync_in, bus.vsync_in});
                #1;
                if (hq.size() >= 3) begin
                    p = hq[hq.size()-3];
                    exp_pix = p.bl ? exp_mem[(int'(p.y) / 4) * 160 + int'(p.x) / 4] : 8'h00;
                    check("scan_pixel", bus.pixel, exp_pix);
                    check("scan_sync", {bus.hsync, bus.vsync, bus.blank_b}, {p.hs, p.vs, p.bl});
                end
                tick();
            end
            $display("scan line %0d: y=%0d done", line, yy);
        end
        bus.blank_b_in = 1'b0;
        tick();

        // ---- reset in the middle of a clear ----
        bus.clr_color = 8'h42; bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        bus.y = 10'd8; bus.blank_b_in = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.x = 10'(c);
            tick();
        end
        bus.hsync_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n0 = wlog.size();
        check("rstmid_busy",  bus.clr_busy, 0);
        check("rstmid_we",    bus.ram_we, 0);
        check("rstmid_hsync", bus.hsync, 1);
        check("rstmid_pixel", bus.pixel, 0);
        check("rstmid_addr",  bus.ram_addr, 0);
        repeat (3) tick();
        bus.blank_b_in = 1'b0; bus.hsync_in = 1'b1;
        rst_n = 1'b1;
        repeat (50) tick();
        check("rstmid_nowrite", wlog.size() - n0, 0);
        check("rstmid_idle",    bus.clr_busy, 0);
        $display("reset mid-clear: writes after reset=%0d", wlog.size() - n0);

        check("slot_write_violations", slot_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
